instr_loader24: RTL and testbench
=================================

# instr_loader24

Byte-stream program loader that fills the 24-bit instruction memory before the core runs. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake. It assembles 24-bit words MSB-first and issues one sequential write per word into the instruction memory's write port. It reports completion, or one of three error classes, so the top level can release the core or retry the load.

## Interface
- address_parameter, 10, instruction memory address width; depth = 2^address_parameter words
- TIMEOUT, 100000, idle cycles allowed between accepted bytes during a load before abort
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader can take a byte this cycle
- wr_en  output  1  one-cycle write strobe to instruction memory
- wr_addr  output  address_parameter  word address for the write
- wr_data  output  24  instruction word for the write
- busy  output  1  load in progress
- done  output  1  last load completed with good checksum
- err  output  1  last load aborted
- err_code  output  2  0 none, 1 oversize, 2 checksum mismatch, 3 timeout
- words_loaded  output  address_parameter+1  words written in the current/last load

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 3·N payload bytes (bits 23:16, 15:8, 7:0 of each word), then one checksum byte equal to the XOR of every preceding frame byte, length bytes included.
- A byte is accepted on a clock edge where in_valid && in_ready.
- States: IDLE, LEN_HI, LEN_LO, WORD, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start -> LEN_HI. On this transition: clear done, err, err_code, words_loaded, running XOR, word index, byte index and timeout counter.
- start in LEN_HI..CHECK is ignored.
- LEN_HI accept -> LEN_LO.
- LEN_LO accept:
  - N > 2^address_parameter -> ERROR, code 1.
  - N == 0 -> CHECK.
  - Otherwise -> WORD.
- WORD: byte index counts 0,1,2.
  - On the third accept, write word at address = word index, then increment word index and words_loaded.
  - After word N-1 -> CHECK.
- CHECK accept: byte == running XOR -> DONE; otherwise -> ERROR, code 2.
- Timeout: in LEN_HI..CHECK the counter increments each cycle without an accept and clears on every accept. When it reaches TIMEOUT -> ERROR, code 3.
- Words written before an abort remain in memory. words_loaded reports how many were written.
- Output decodes:
  - in_ready = 1 only in LEN_HI, LEN_LO, WORD, CHECK.
  - busy = same set of states.
  - done = 1 only in DONE; err = 1 only in ERROR; both held until next start.
- Reset (any state, including mid-load): state IDLE. Every output 0: in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_code, words_loaded. Running XOR and all counters 0.
- wr_addr never exceeds 2^address_parameter − 1. Word index wraps nowhere because oversize is rejected at LEN_LO.

## Timing
- All outputs registered or decoded from registered state; no combinational path from in_valid/in_data to any output.
- wr_en is high for exactly one cycle: the cycle after the edge that accepted a word's third byte. wr_addr/wr_data are valid in that cycle.
- in_ready stays high during the wr_en cycle, so back-to-back bytes sustain one byte per cycle. The first byte of the next word may be accepted in the wr_en cycle.
- State transitions and error/done flags:
  - Busy state is entered the cycle after start.
  - done/err assert the cycle after the deciding accept, or after the timeout count is reached.
  - busy deasserts in that same cycle.
- Timeout: err asserts exactly TIMEOUT cycles after the last accept, or after start, with no intervening accept.
- start coincident with in_valid in IDLE: the byte is not accepted (in_ready is 0).
- rst wins over start and over any accept in the same cycle.

## Test plan
- Good frame 00 02 12 34 56 AB CD EF FB, in_valid held high:
  - in_ready goes high the cycle after start.
  - wr_en at addr 0 data 123456, then addr 1 data ABCDEF, each one cycle.
  - done=1, words_loaded=2, err=0.
- Empty frame 00 00 00 -> no wr_en, done=1, words_loaded=0.
- Oversize with address_parameter=10:
  - 04 01 -> err=1, code 1 after LEN_LO, no writes.
  - 04 00 is accepted into WORD state.
- Checksum mismatch: good frame with trailer FA -> both writes occur, err=1, code 2, words_loaded=2, done=0.
- Timeout with TIMEOUT=16: after start send 00 01 12, then drop in_valid -> err=1, code 3 exactly 16 cycles after the 12 accept, no wr_en.
- Reset mid-load: assert rst after 5 payload bytes -> next cycle all outputs 0, state IDLE. A subsequent start plus good frame loads correctly from addr 0.

Source files
------------

// File: rtl/instr_loader24.sv
// Byte-stream program loader: parses a length/payload/checksum frame and writes
// 24-bit words sequentially into the instruction memory write port.
module instr_loader24 #(
    parameter int unsigned address_parameter = 10,
    parameter int unsigned TIMEOUT           = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [7:0]                   in_data,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [address_parameter-1:0] wr_addr,
    output logic [23:0]                  wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [address_parameter:0]   words_loaded
);

    localparam int unsigned AW = address_parameter;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT - 1);
    localparam logic [16:0]   MaxWords = 17'(2 ** AW);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StWord,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [1:0]      r_err_code;
    logic [1:0]      w_code_next;
    logic [15:0]     r_len;
    logic [7:0]      r_xor;
    logic [1:0]      r_byte_idx;
    logic [15:0]     r_word_buf;
    logic [TW-1:0]   r_tmo;
    logic [AW:0]     r_words_loaded;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [23:0]     r_wr_data;

    logic            w_busy;
    logic            w_idle_like;
    logic            w_start_ok;
    logic            w_accept;
    logic            w_tmo_hit;
    logic            w_word_last;
    logic [15:0]     w_len;

    always_comb begin
        w_busy      = (r_state == StLenHi) || (r_state == StLenLo) ||
                      (r_state == StWord)  || (r_state == StCheck);
        w_idle_like = (r_state == StIdle) || (r_state == StDone) || (r_state == StError);
        w_start_ok  = start && w_idle_like;
        w_accept    = in_valid && w_busy;
        w_len       = {r_len[15:8], in_data};
        w_tmo_hit   = w_busy && !w_accept && (r_tmo == TmoLast);
        w_word_last = (r_byte_idx == 2'd2) &&
                      ((17'(r_words_loaded) + 17'd1) == {1'b0, r_len});
    end

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_err_code;
        unique case (r_state)
            StIdle, StDone, StError: begin
                if (start) begin
                    w_state_next = StLenHi;
                    w_code_next  = 2'd0;
                end
            end
            StLenHi: begin
                if (w_accept) w_state_next = StLenLo;
            end
            StLenLo: begin
                if (w_accept) begin
                    if ({1'b0, w_len} > MaxWords) begin
                        w_state_next = StError;
                        w_code_next  = 2'd1;
                    end else if (w_len == 16'd0) begin
                        w_state_next = StCheck;
                    end else begin
                        w_state_next = StWord;
                    end
                end
            end
            StWord: begin
                if (w_accept && w_word_last) w_state_next = StCheck;
            end
            StCheck: begin
                if (w_accept) begin
                    if (in_data == r_xor) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StError;
                        w_code_next  = 2'd2;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
        // A timeout can only fire on a cycle without an accept, so it never races a decision.
        if (w_tmo_hit) begin
            w_state_next = StError;
            w_code_next  = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_err_code     <= 2'd0;
            r_len          <= 16'd0;
            r_xor          <= 8'd0;
            r_byte_idx     <= 2'd0;
            r_word_buf     <= 16'd0;
            r_tmo          <= '0;
            r_words_loaded <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= 24'd0;
        end else begin
            r_state    <= w_state_next;
            r_err_code <= w_code_next;
            r_wr_en    <= 1'b0;
            if (w_start_ok) begin
                r_xor          <= 8'd0;
                r_byte_idx     <= 2'd0;
                r_tmo          <= '0;
                r_words_loaded <= '0;
            end else if (w_accept) begin
                r_tmo <= '0;
                r_xor <= r_xor ^ in_data;
                if (r_state == StLenHi) r_len[15:8] <= in_data;
                if (r_state == StLenLo) r_len[7:0]  <= in_data;
                if (r_state == StWord) begin
                    unique case (r_byte_idx)
                        2'd0: begin
                            r_word_buf[15:8] <= in_data;
                            r_byte_idx       <= 2'd1;
                        end
                        2'd1: begin
                            r_word_buf[7:0] <= in_data;
                            r_byte_idx      <= 2'd2;
                        end
                        default: begin
                            r_wr_en        <= 1'b1;
                            r_wr_addr      <= r_words_loaded[AW-1:0];
                            r_wr_data      <= {r_word_buf, in_data};
                            r_words_loaded <= r_words_loaded + {{AW{1'b0}}, 1'b1};
                            r_byte_idx     <= 2'd0;
                        end
                    endcase
                end
            end else if (w_busy) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign in_ready     = w_busy;
    assign busy         = w_busy;
    assign done         = (r_state == StDone);
    assign err          = (r_state == StError);
    assign err_code     = r_err_code;
    assign words_loaded = r_words_loaded;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;

endmodule

// File: tb/tb_instr_loader24.sv
// Scoreboard bench for instr_loader24: expected writes are queued as frames are
// driven and matched against each wr_en strobe.
module tb_instr_loader24;

    localparam int unsigned AW  = 10;
    localparam int unsigned TMO = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    logic [33:0] exp_q[$];
    logic [23:0] pay[$];

    instr_loader24 #(
        .address_parameter(AW),
        .TIMEOUT          (TMO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check_value("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check_value("wr_addr", 32'(wr_addr), 32'(e[33:24]));
                check_value("wr_data", 32'(wr_data), 32'(e[23:0]));
            end
        end
    end

    // Leaves in_valid high; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check_value("ready_wait", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [7:0] ck_flip);
        logic [7:0] x;
        x = n[15:8] ^ n[7:0];
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < pay.size(); i++) begin
            exp_q.push_back({AW'(i), pay[i]});
            x = x ^ pay[i][23:16] ^ pay[i][15:8] ^ pay[i][7:0];
            send_byte(pay[i][23:16]);
            send_byte(pay[i][15:8]);
            send_byte(pay[i][7:0]);
        end
        send_byte(x ^ ck_flip);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] agg;
        agg = {in_ready, wr_en, busy, done, err, err_code, 32'(words_loaded), 22'(wr_addr)};
        check_value({tag, "_ctl"}, agg[63:32], 32'd0);
        check_value({tag, "_cnt"}, agg[31:0], 32'd0);
        check_value({tag, "_wdata"}, 32'(wr_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        // Good frame; start coincides with in_valid in IDLE, which must not be accepted.
        in_valid = 1'b1;
        in_data  = 8'h00;
        check_value("idle_ready", 32'(in_ready), 32'd0);
        do_start();
        check_value("ready_after_start", 32'(in_ready), 32'd1);
        check_value("busy_after_start", 32'(busy), 32'd1);
        pay = '{24'h123456, 24'hABCDEF};
        send_frame(16'd2, 8'h00);
        check_value("good_done", 32'(done), 32'd1);
        check_value("good_err", 32'(err), 32'd0);
        check_value("good_busy", 32'(busy), 32'd0);
        check_value("good_words", 32'(words_loaded), 32'd2);
        idle_cycles(2);
        check_value("good_sb_empty", 32'(exp_q.size()), 32'd0);

        // Empty frame.
        do_start();
        check_value("restart_done_clr", 32'(done), 32'd0);
        pay = {};
        send_frame(16'd0, 8'h00);
        check_value("empty_done", 32'(done), 32'd1);
        check_value("empty_words", 32'(words_loaded), 32'd0);
        idle_cycles(2);

        // Oversize: 1025 words.
        do_start();
        send_byte(8'h04);
        send_byte(8'h01);
        check_value("over_err", 32'(err), 32'd1);
        check_value("over_code", 32'(err_code), 32'd1);
        check_value("over_busy", 32'(busy), 32'd0);
        check_value("over_words", 32'(words_loaded), 32'd0);
        idle_cycles(2);

        // Exactly 1024 words is legal; let it time out afterwards.
        do_start();
        check_value("restart_err_clr", 32'(err), 32'd0);
        send_byte(8'h04);
        send_byte(8'h00);
        check_value("max_busy", 32'(busy), 32'd1);
        check_value("max_err", 32'(err), 32'd0);
        idle_cycles(TMO);
        check_value("max_tmo_code", 32'(err_code), 32'd3);
        idle_cycles(2);

        // Checksum mismatch (FB -> FA).
        do_start();
        pay = '{24'h123456, 24'hABCDEF};
        send_frame(16'd2, 8'h01);
        check_value("ck_err", 32'(err), 32'd1);
        check_value("ck_code", 32'(err_code), 32'd2);
        check_value("ck_done", 32'(done), 32'd0);
        check_value("ck_words", 32'(words_loaded), 32'd2);
        idle_cycles(2);

        // Timeout exactly TMO cycles after the last accept.
        do_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        idle_cycles(TMO - 1);
        check_value("tmo_early", 32'(err), 32'd0);
        idle_cycles(1);
        check_value("tmo_err", 32'(err), 32'd1);
        check_value("tmo_code", 32'(err_code), 32'd3);
        check_value("tmo_words", 32'(words_loaded), 32'd0);
        idle_cycles(2);

        // Reset after 5 payload bytes, with start and in_valid also high.
        do_start();
        exp_q.push_back({AW'(0), 24'h123456});
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'hAB);
        send_byte(8'hCD);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        idle_cycles(2);
        check_value("midrst_idle", 32'(busy), 32'd0);

        do_start();
        pay = '{24'h123456, 24'hABCDEF};
        send_frame(16'd2, 8'h00);
        check_value("reload_done", 32'(done), 32'd1);
        check_value("reload_words", 32'(words_loaded), 32'd2);
        idle_cycles(3);
        check_value("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
